// File: rtl/tbuart_if.sv
// Host-side bus of the tbuart block: transmit request/status and received-byte outputs.
interface tbuart_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    // Requester side: drives the transmit request, observes status and received data.
    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
    );

    // UART side.
    modport slave (
        input  tx_start, tx_data,
        output tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
    );
endinterface

// File: rtl/tbuart.sv
// tbuart: 8N1 UART with independent transmitter and receiver.
// Optional macro TBUART_FRAMING_CHECK_EN: when defined, a receive frame with a
// 0 stop bit raises rx_frame_err instead of delivering the byte.
module tbuart #(
    parameter int unsigned CLKS_PER_BIT = 4167
) (
    input  logic    clock,
    input  logic    resetb,
    input  logic    ser_rx,
    output logic    ser_tx,
    tbuart_if.slave host
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 3;
    localparam int unsigned BYTE_W = 8;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_e              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]    tx_bit_q, tx_bit_d;
    logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
    logic                ser_tx_q, ser_tx_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_clear_q, tx_clear_d;
    logic                armed_q, armed_d;
    logic                tx_last;

    // Transmit next-state: one bit period per state step, armed gates a new frame.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        ser_tx_d   = ser_tx_q;
        tx_busy_d  = tx_busy_q;
        tx_clear_d = 1'b0;
        armed_d    = armed_q | ~host.tx_start;
        tx_last    = (tx_cnt_q == BIT_LAST);
        tx_cnt_d   = tx_last ? '0 : tx_cnt_q + CNT_W'(1);

        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (host.tx_start && armed_q) begin
                    tx_state_d = ST_START;
                    tx_shift_d = host.tx_data;
                    armed_d    = 1'b0;
                    ser_tx_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_last) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                    ser_tx_d   = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_last) begin
                    if (tx_bit_q == LAST_DATA_BIT) begin
                        tx_state_d = ST_STOP;
                        ser_tx_d   = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[BYTE_W-1:1]};
                        ser_tx_d   = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tx_last) begin
                    tx_state_d = ST_IDLE;
                    tx_busy_d  = 1'b0;
                    tx_clear_d = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Transmit state register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            ser_tx_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_clear_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            ser_tx_q   <= ser_tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_clear_q <= tx_clear_d;
            armed_q    <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_e              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]    rx_bit_q, rx_bit_d;
    logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_err_q, rx_err_d;
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    logic                rx_fall;

    // Receive next-state: detect start edge, confirm at half bit, then sample each mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_fall    = rx_prev_q & ~rx_sync_q;

        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[BYTE_W-1:1]};
                    if (rx_bit_q == LAST_DATA_BIT) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
`ifdef TBUART_FRAMING_CHECK_EN
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d   = 1'b1;
                    end
`else
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
`endif
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // Receive state register plus the two-flop synchronizer and edge-history flop.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_meta_q  <= ser_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign ser_tx            = ser_tx_q;
    assign host.tx_busy      = tx_busy_q;
    assign host.tx_clear_req = tx_clear_q;
    assign host.rx_data      = rx_data_q;
    assign host.rx_valid     = rx_valid_q;
    assign host.rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_tbuart.sv
// Self-checking bench for tbuart with CLKS_PER_BIT=16: frame-level model of the
// transmitter plus a receive scoreboard, and directed literal checks.
module tb_tbuart;
    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    logic ser_rx = 1'b1;
    logic ser_tx;

    tbuart_if u_if ();

    tbuart #(.CLKS_PER_BIT(CPB)) u_dut (
        .clock  (clock),
        .resetb (resetb),
        .ser_rx (ser_rx),
        .ser_tx (ser_tx),
        .host   (u_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmit model: a frame is "active" for FRAME cycles; the line level is
    // looked up from the frame offset.
    logic       m_armed  = 1'b0;
    logic       m_active = 1'b0;
    logic       m_clr    = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_byte   = 8'h00;

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            m_armed  <= 1'b0;
            m_active <= 1'b0;
            m_clr    <= 1'b0;
            m_k      <= 0;
        end else begin
            m_clr <= 1'b0;
            if (!u_if.tx_start) m_armed <= 1'b1;
            if (m_active) begin
                if (m_k == FRAME - 1) begin
                    m_active <= 1'b0;
                    m_clr    <= 1'b1;
                    m_k      <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (u_if.tx_start && m_armed) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_byte   <= u_if.tx_data;
                m_armed  <= 1'b0;
            end
        end
    end

    // Receive scoreboard: one entry per frame the bench puts on ser_rx.
    typedef struct {
        logic       err;
        logic [7:0] data;
    } rx_exp_t;
    rx_exp_t    rx_q[$];
    logic [7:0] last_good = 8'h00;

    int   clr_cnt       = 0;
    int   busy_rise_cnt = 0;
    int   rxv_cnt       = 0;
    int   rxe_cnt       = 0;
    logic prev_busy     = 1'b0;

    // Per-cycle compare against the model and scoreboard.
    initial begin
        rx_exp_t e;
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("ser_tx", 32'(ser_tx), 32'(m_active ? exp_bit(m_byte, m_k) : 1'b1));
            check("tx_busy", 32'(u_if.tx_busy), 32'(m_active));
            check("tx_clear_req", 32'(u_if.tx_clear_req), 32'(m_clr));
            if (u_if.tx_clear_req) clr_cnt++;
            if (u_if.tx_busy && !prev_busy) busy_rise_cnt++;
            prev_busy = u_if.tx_busy;
            if (u_if.rx_valid) rxv_cnt++;
            if (u_if.rx_frame_err) rxe_cnt++;
            if (!resetb) begin
                check("rst_rx_data", 32'(u_if.rx_data), 32'h0);
                check("rst_rx_valid", 32'(u_if.rx_valid), 32'h0);
                check("rst_rx_frame_err", 32'(u_if.rx_frame_err), 32'h0);
            end else if (u_if.rx_valid || u_if.rx_frame_err) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_pulse", 32'({u_if.rx_valid, u_if.rx_frame_err}), 32'h0);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_valid", 32'(u_if.rx_valid), 32'(!e.err));
                    check("rx_frame_err", 32'(u_if.rx_frame_err), 32'(e.err));
                    if (!e.err) begin
                        check("rx_data", 32'(u_if.rx_data), 32'(e.data));
                        last_good = e.data;
                    end else begin
                        check("rx_data_hold", 32'(u_if.rx_data), 32'(last_good));
                    end
                end
            end
        end
    end

    task automatic wait_busy(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (u_if.tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Walk a frame from its first busy cycle, sampling ser_tx mid-bit.
    task automatic run_frame(output logic [9:0] bits, output int ncyc, output logic clr_end);
        bits = '0;
        ncyc = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!u_if.tx_busy) break;
            ncyc++;
            if (i < FRAME && (i % CPB) == CPB / 2) bits[i / CPB] = ser_tx;
            if (i == 50) u_if.tx_data = 8'hF0;
            @(negedge clock);
        end
        clr_end = u_if.tx_clear_req;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_exp_t e;
`ifdef TBUART_FRAMING_CHECK_EN
        e.err = ~stop;
`else
        e.err = 1'b0;
`endif
        e.data = d;
        rx_q.push_back(e);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            ser_rx = d[i];
            repeat (CPB) @(negedge clock);
        end
        ser_rx = stop;
        repeat (CPB) @(negedge clock);
        ser_rx = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        logic [9:0] exp_bits;
        int         ncyc;
        logic       clr_end;
        logic       ok;
        int         clr_before;

        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'h55;
        resetb = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ser_tx", 32'(ser_tx), 32'h1);
        check("rst_tx_busy", 32'(u_if.tx_busy), 32'h0);
        check("rst_tx_clear_req", 32'(u_if.tx_clear_req), 32'h0);
        check("rst_rx_data_lit", 32'(u_if.rx_data), 32'h0);
        resetb = 1'b1;

        // tx_start held high out of reset must not send
        repeat (30) @(negedge clock);
        check("no_frame_unarmed", 32'(busy_rise_cnt), 32'd0);

        // 0x0F frame, tx_data changed mid-frame
        clr_before = clr_cnt;
        u_if.tx_start = 1'b0;
        @(negedge clock);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'h0F;
        wait_busy(40, ok);
        check("t0f_start", 32'(ok), 32'h1);
        run_frame(bits, ncyc, clr_end);
        exp_bits = 10'b1000011110;
        check("t0f_bits", 32'(bits), 32'(exp_bits));
        check("t0f_busy_cycles", 32'(ncyc), 32'd160);
        check("t0f_clear_at_end", 32'(clr_end), 32'h1);
        repeat (5) @(negedge clock);
        check("t0f_one_clear", 32'(clr_cnt - clr_before), 32'd1);

        // held tx_start: no second frame until low then high
        repeat (40) @(negedge clock);
        check("held_no_refire", 32'(busy_rise_cnt), 32'd1);
        u_if.tx_data  = 8'h3D;
        u_if.tx_start = 1'b0;
        @(negedge clock);
        u_if.tx_start = 1'b1;
        wait_busy(40, ok);
        check("t3d_start", 32'(ok), 32'h1);
        run_frame(bits, ncyc, clr_end);
        exp_bits = 10'b1001111010;
        check("t3d_bits", 32'(bits), 32'(exp_bits));
        check("t3d_busy_cycles", 32'(ncyc), 32'd160);
        repeat (200) @(negedge clock);
        check("t3d_exactly_one", 32'(busy_rise_cnt), 32'd2);
        u_if.tx_start = 1'b0;
        @(negedge clock);
        u_if.tx_start = 1'b1;
        wait_busy(40, ok);
        check("rearm_start", 32'(ok), 32'h1);

        // reset in the middle of a frame
        repeat (50) @(negedge clock);
        clr_before = clr_cnt;
        #2 resetb = 1'b0;
        #1;
        check("midrst_ser_tx", 32'(ser_tx), 32'h1);
        check("midrst_tx_busy", 32'(u_if.tx_busy), 32'h0);
        repeat (4) @(negedge clock);
        resetb = 1'b1;
        repeat (20) @(negedge clock);
        check("midrst_no_clear", 32'(clr_cnt - clr_before), 32'd0);
        check("midrst_no_restart", 32'(busy_rise_cnt), 32'd3);

        // receive: back-to-back frames
        send_frame(8'hAB, 1'b1);
        check("rx_ab_lit", 32'(u_if.rx_data), 32'hAB);
        send_frame(8'h40, 1'b1);
        repeat (20) @(negedge clock);
        check("rx_40_lit", 32'(u_if.rx_data), 32'h40);
        check("rx_two_valid", 32'(rxv_cnt), 32'd2);

        // 3-cycle glitch
        ser_rx = 1'b0;
        repeat (3) @(negedge clock);
        ser_rx = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_no_valid", 32'(rxv_cnt), 32'd2);
        check("glitch_no_err", 32'(rxe_cnt), 32'd0);

        // bad stop bit
        send_frame(8'h5A, 1'b0);
        repeat (40) @(negedge clock);
`ifdef TBUART_FRAMING_CHECK_EN
        check("badstop_err", 32'(rxe_cnt), 32'd1);
        check("badstop_valid", 32'(rxv_cnt), 32'd2);
        check("badstop_data", 32'(u_if.rx_data), 32'h40);
`else
        check("badstop_err", 32'(rxe_cnt), 32'd0);
        check("badstop_valid", 32'(rxv_cnt), 32'd3);
        check("badstop_data", 32'(u_if.rx_data), 32'h5A);
`endif

        // transmit and receive concurrently
        u_if.tx_data  = 8'hA5;
        u_if.tx_start = 1'b0;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                @(negedge clock);
                u_if.tx_start = 1'b1;
            end
        join
        repeat (40) @(negedge clock);
        check("dual_rx_data", 32'(u_if.rx_data), 32'hC3);
        check("dual_tx_frames", 32'(busy_rise_cnt), 32'd4);
        check("rx_scoreboard_empty", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
